// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: datapath widths, memory
// opcode encodings, FSM state type and opcode classification helpers.
package mem_access_stage_pkg;

  localparam int XLEN      = 64;
  localparam int MEMOP_LEN = 4;
  localparam int RADDR_W   = 5;

  // Memory opcode encodings, shared with the decoder. Codes 12..15 are unused
  // and behave exactly like MEMOP_NONE.
  localparam logic [MEMOP_LEN-1:0] MEMOP_NONE = 4'd0;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LB   = 4'd1;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LBU  = 4'd2;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LH   = 4'd3;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LHU  = 4'd4;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LW   = 4'd5;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LWU  = 4'd6;
  localparam logic [MEMOP_LEN-1:0] MEMOP_LD   = 4'd7;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SB   = 4'd8;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SH   = 4'd9;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SW   = 4'd10;
  localparam logic [MEMOP_LEN-1:0] MEMOP_SD   = 4'd11;

  // Access sizes: byte, half, word, double.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic memop_is_load(input logic [MEMOP_LEN-1:0] op);
    return (op >= MEMOP_LB) && (op <= MEMOP_LD);
  endfunction

  function automatic logic memop_is_store(input logic [MEMOP_LEN-1:0] op);
    return (op >= MEMOP_SB) && (op <= MEMOP_SD);
  endfunction

  function automatic logic memop_is_signed(input logic [MEMOP_LEN-1:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW);
  endfunction

  function automatic logic [1:0] memop_size(input logic [MEMOP_LEN-1:0] op);
    logic [1:0] sz;
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: sz = SIZE_B;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: sz = SIZE_H;
      MEMOP_LW, MEMOP_LWU, MEMOP_SW: sz = SIZE_W;
      default:                       sz = SIZE_D;
    endcase
    return sz;
  endfunction

  // True when a load/store is not naturally aligned for its size.
  function automatic logic memop_misaligned(input logic [MEMOP_LEN-1:0] op,
                                            input logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (memop_is_load(op) || memop_is_store(op)) begin
      case (memop_size(op))
        SIZE_H:  mis = addr_lo[0];
        SIZE_W:  mis = |addr_lo[1:0];
        SIZE_D:  mis = |addr_lo;
        default: mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_ext.sv
// Combinational byte-lane logic: aligns and extends load data coming back
// from the 8-byte bus, and builds the store byte mask and lane-shifted data.
module mem_load_ext
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic [MEMOP_LEN-1:0] i_memop,
  input  logic [2:0]           i_addr_lo,
  input  logic [XLEN_P-1:0]    i_rdata,
  input  logic [XLEN_P-1:0]    i_rs2,
  output logic [XLEN_P-1:0]    o_load_data,
  output logic [7:0]           o_wmask,
  output logic [XLEN_P-1:0]    o_wdata
);

  logic [5:0]        w_shamt;
  logic [XLEN_P-1:0] w_shifted;
  logic              w_sgn;
  logic [7:0]        w_base_mask;

  // Shift the addressed lane down to bit 0, then sign/zero extend by size.
  always_comb begin
    w_shamt   = {i_addr_lo, 3'b000};
    w_shifted = i_rdata >> w_shamt;
    w_sgn     = memop_is_signed(i_memop);
    case (memop_size(i_memop))
      SIZE_B:  o_load_data = {{(XLEN_P-8){w_sgn & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_H:  o_load_data = {{(XLEN_P-16){w_sgn & w_shifted[15]}}, w_shifted[15:0]};
      SIZE_W:  o_load_data = {{(XLEN_P-32){w_sgn & w_shifted[31]}}, w_shifted[31:0]};
      default: o_load_data = w_shifted;
    endcase
  end

  // Store lanes: size mask and data both move up by the byte offset.
  always_comb begin
    case (memop_size(i_memop))
      SIZE_B:  w_base_mask = 8'h01;
      SIZE_H:  w_base_mask = 8'h03;
      SIZE_W:  w_base_mask = 8'h0F;
      default: w_base_mask = 8'hFF;
    endcase
    o_wmask = memop_is_store(i_memop) ? (w_base_mask << i_addr_lo) : 8'h00;
    o_wdata = i_rs2 << {i_addr_lo, 3'b000};
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: holds one instruction, issues at most one data-memory
// transaction, formats load data and hands a packet to write-back.
//
// Handshake semantics: a transfer on any valid/ready pair happens on a rising
// clock edge where both valid and ready are high. This stage never drops a
// raised valid (in_ready, dmem_req_valid, out_valid) until its transfer, and
// keeps the payload of a raised valid constant until then. dmem_rsp_valid has
// no ready; a response is taken only while waiting for one.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN_P      = XLEN,
  parameter int MEMOP_LEN_P = MEMOP_LEN,
  parameter int RADDR_W_P   = RADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN_P-1:0]      in_pc,
  input  logic [RADDR_W_P-1:0]   in_rd_idx,
  input  logic [XLEN_P-1:0]      in_alu_out,
  input  logic [XLEN_P-1:0]      in_rs2_data,
  input  logic [MEMOP_LEN_P-1:0] in_memop,
  output logic                   dmem_req_valid,
  input  logic                   dmem_req_ready,
  output logic                   dmem_req_wen,
  output logic [XLEN_P-1:0]      dmem_req_addr,
  output logic [XLEN_P-1:0]      dmem_req_wdata,
  output logic [7:0]             dmem_req_wmask,
  input  logic                   dmem_rsp_valid,
  input  logic [XLEN_P-1:0]      dmem_rsp_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN_P-1:0]      out_pc,
  output logic [RADDR_W_P-1:0]   out_rd_idx,
  output logic [XLEN_P-1:0]      out_wb_data,
  output logic                   out_misalign,
  output state_t                 dbg_state
);

  state_t                 r_state;
  state_t                 w_next;
  logic [XLEN_P-1:0]      r_pc;
  logic [RADDR_W_P-1:0]   r_rd_idx;
  logic [XLEN_P-1:0]      r_addr;
  logic [XLEN_P-1:0]      r_rs2;
  logic [MEMOP_LEN_P-1:0] r_memop;
  logic [XLEN_P-1:0]      r_wb_data;
  logic                   r_misalign;

  logic                   w_in_mem;
  logic                   w_in_misalign;
  logic [XLEN_P-1:0]      w_load_data;
  logic [7:0]             w_wmask;
  logic [XLEN_P-1:0]      w_wdata;

  assign w_in_mem      = memop_is_load(in_memop) || memop_is_store(in_memop);
  assign w_in_misalign = memop_misaligned(in_memop, in_alu_out[2:0]);

  mem_load_ext #(.XLEN_P(XLEN_P)) u_load_ext (
    .i_memop     (r_memop),
    .i_addr_lo   (r_addr[2:0]),
    .i_rdata     (dmem_rsp_rdata),
    .i_rs2       (r_rs2),
    .o_load_data (w_load_data),
    .o_wmask     (w_wmask),
    .o_wdata     (w_wdata)
  );

  // State register; reset abandons any in-flight bus transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (!w_in_mem || w_in_misalign) w_next = ST_DONE;
          else                            w_next = ST_REQ;
        end
      end
      ST_REQ:  if (dmem_req_ready) w_next = ST_WAIT;
      ST_WAIT: if (dmem_rsp_valid) w_next = ST_DONE;
      ST_DONE: if (out_ready)      w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; request fields are zero outside REQ.
  always_comb begin
    in_ready       = (r_state == ST_IDLE);
    out_valid      = (r_state == ST_DONE);
    dmem_req_valid = (r_state == ST_REQ);
    dmem_req_wen   = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_wdata = '0;
    dmem_req_wmask = 8'h00;
    if (r_state == ST_REQ) begin
      dmem_req_wen   = memop_is_store(r_memop);
      dmem_req_addr  = {r_addr[XLEN_P-1:3], 3'b000};
      dmem_req_wdata = w_wdata;
      dmem_req_wmask = w_wmask;
    end
  end

  // Packet latch on accept, write-back data capture on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_rd_idx   <= '0;
      r_addr     <= '0;
      r_rs2      <= '0;
      r_memop    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_pc       <= in_pc;
            r_rd_idx   <= in_rd_idx;
            r_addr     <= in_alu_out;
            r_rs2      <= in_rs2_data;
            r_memop    <= in_memop;
            r_misalign <= w_in_misalign;
            // Non-memory ops pass the ALU result; memory ops fill it later.
            r_wb_data  <= w_in_mem ? '0 : in_alu_out;
          end
        end
        ST_WAIT: begin
          if (dmem_rsp_valid)
            r_wb_data <= memop_is_load(r_memop) ? w_load_data : '0;
        end
        ST_DONE: begin
          if (out_ready) r_misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_pc       = r_pc;
  assign out_rd_idx   = r_rd_idx;
  assign out_wb_data  = r_wb_data;
  assign out_misalign = r_misalign;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a write-back scoreboard.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd_idx;
  logic [63:0] in_alu_out;
  logic [63:0] in_rs2_data;
  logic [3:0]  in_memop;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_wen;
  logic [63:0] dmem_req_addr;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rd_idx;
  logic [63:0] out_wb_data;
  logic        out_misalign;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  // {misalign, pc, wb_data}
  logic [128:0] exp_q[$];

  mem_access_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rd_idx      (in_rd_idx),
    .in_alu_out     (in_alu_out),
    .in_rs2_data    (in_rs2_data),
    .in_memop       (in_memop),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_wen   (dmem_req_wen),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_wmask (dmem_req_wmask),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_rd_idx     (out_rd_idx),
    .out_wb_data    (out_wb_data),
    .out_misalign   (out_misalign),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full packet: accept, optional bus request/response, write-back handoff.
  task automatic txn(input logic [3:0] op, input logic [63:0] alu, input logic [63:0] rs2,
                     input logic [63:0] pc, input logic [63:0] rdata,
                     input int req_dly, input int rsp_dly, input int out_dly,
                     input logic exp_req, input logic exp_mis, input logic [7:0] exp_mask,
                     input logic [63:0] exp_wdata, input logic [63:0] exp_wb, input logic chk_wb);
    logic [128:0] e;
    logic [63:0]  eaddr;
    eaddr = {alu[63:3], 3'b000};
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    in_memop    = op;
    in_alu_out  = alu;
    in_rs2_data = rs2;
    in_pc       = pc;
    in_rd_idx   = pc[4:0];
    exp_q.push_back({exp_mis, pc, exp_wb});
    @(negedge clk);
    // Scramble inputs after accept: the stage must work from latched copies.
    in_valid    = 1'b0;
    in_alu_out  = {$urandom, $urandom};
    in_rs2_data = {$urandom, $urandom};
    in_pc       = {$urandom, $urandom};
    in_memop    = 4'($urandom_range(0, 15));
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    if (exp_req) begin
      for (int i = 0; i <= req_dly; i++) begin
        // Stray response during REQ must be ignored.
        dmem_rsp_valid = (i == 0 && req_dly > 1);
        dmem_rsp_rdata = {$urandom, $urandom};
        if (i == req_dly) dmem_req_ready = 1'b1;
        chk("req_valid", 64'(dmem_req_valid), 64'd1);
        chk("req_addr", dmem_req_addr, eaddr);
        chk("req_wen", 64'(dmem_req_wen), 64'(exp_mask != 8'h00));
        chk("req_wmask", 64'(dmem_req_wmask), 64'(exp_mask));
        if (exp_mask != 8'h00) chk("req_wdata", dmem_req_wdata, exp_wdata);
        chk("in_ready_req", 64'(in_ready), 64'd0);
        @(negedge clk);
      end
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      chk("req_valid_wait", 64'(dmem_req_valid), 64'd0);
      for (int i = 0; i < rsp_dly; i++) begin
        chk("out_valid_wait", 64'(out_valid), 64'd0);
        chk("in_ready_wait", 64'(in_ready), 64'd0);
        @(negedge clk);
      end
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = rdata;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = {$urandom, $urandom};
    end else begin
      chk("no_req", 64'(dmem_req_valid), 64'd0);
    end
    for (int i = 0; i < out_dly; i++) begin
      chk("out_valid_hold", 64'(out_valid), 64'd1);
      chk("in_ready_done", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("out_valid", 64'(out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("out_pc", out_pc, e[127:64]);
      chk("out_rd_idx", 64'(out_rd_idx), 64'(e[68:64]));
      chk("out_misalign", 64'(out_misalign), 64'(e[128]));
      if (chk_wb) chk("out_wb_data", out_wb_data, e[63:0]);
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after", 64'(out_valid), 64'd0);
    chk("misalign_after", 64'(out_misalign), 64'd0);
    chk("in_ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_pc          = '0;
    in_rd_idx      = '0;
    in_alu_out     = '0;
    in_rs2_data    = '0;
    in_memop       = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_wb_data", out_wb_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Response while idle is ignored.
    dmem_rsp_valid = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("idle_rsp_ignored", 64'(out_valid), 64'd0);

    // op, alu, rs2, pc, rdata, req_dly, rsp_dly, out_dly, req, mis, mask, wdata, wb, chk_wb
    txn(MEMOP_NONE, 64'h1234, 64'h0, 64'h100, 64'h0, 0, 0, 0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h1234, 1'b1);
    txn(MEMOP_LB, 64'h1003, 64'h0, 64'h104, 64'h00000000_80000000, 0, 0, 0,
        1'b1, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80, 1'b1);
    txn(MEMOP_LBU, 64'h1003, 64'h0, 64'h108, 64'h00000000_80000000, 0, 0, 0,
        1'b1, 1'b0, 8'h00, 64'h0, 64'h80, 1'b1);
    txn(MEMOP_SH, 64'h1006, 64'hABCD, 64'h10C, 64'h0, 0, 0, 0,
        1'b1, 1'b0, 8'hC0, 64'hABCD0000_00000000, 64'h0, 1'b1);
    txn(MEMOP_LW, 64'h1002, 64'h0, 64'h110, 64'h0, 0, 0, 0, 1'b0, 1'b1, 8'h00, 64'h0, 64'h0, 1'b0);
    txn(MEMOP_LD, 64'h2000, 64'h0, 64'h114, 64'h01234567_89ABCDEF, 3, 2, 2,
        1'b1, 1'b0, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 1'b1);
    txn(MEMOP_LH, 64'h100A, 64'h0, 64'h118, 64'h11223344_F5667788, 1, 0, 0,
        1'b1, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFF566, 1'b1);
    txn(MEMOP_LHU, 64'h100A, 64'h0, 64'h11C, 64'h11223344_F5667788, 0, 1, 0,
        1'b1, 1'b0, 8'h00, 64'h0, 64'h00000000_0000F566, 1'b1);
    txn(MEMOP_LW, 64'h1004, 64'h0, 64'h120, 64'h8899AABB_00000000, 0, 0, 1,
        1'b1, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFF_8899AABB, 1'b1);
    txn(MEMOP_LWU, 64'h1004, 64'h0, 64'h124, 64'h8899AABB_00000000, 0, 0, 0,
        1'b1, 1'b0, 8'h00, 64'h0, 64'h00000000_8899AABB, 1'b1);
    txn(MEMOP_SW, 64'h3004, 64'hDEADBEEF, 64'h128, 64'h0, 2, 1, 0,
        1'b1, 1'b0, 8'hF0, 64'hDEADBEEF_00000000, 64'h0, 1'b1);
    txn(MEMOP_SB, 64'h3005, 64'h5A, 64'h12C, 64'h0, 0, 0, 0,
        1'b1, 1'b0, 8'h20, 64'h00005A00_00000000, 64'h0, 1'b1);
    txn(MEMOP_SD, 64'h3008, 64'h0F1E2D3C_4B5A6978, 64'h130, 64'h0, 0, 0, 0,
        1'b1, 1'b0, 8'hFF, 64'h0F1E2D3C_4B5A6978, 64'h0, 1'b1);
    txn(MEMOP_SD, 64'h3001, 64'h1, 64'h134, 64'h0, 0, 0, 0, 1'b0, 1'b1, 8'h00, 64'h0, 64'h0, 1'b0);
    txn(4'hF, 64'h55, 64'h0, 64'h138, 64'h0, 0, 0, 0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h55, 1'b1);

    // Reset while waiting for a response abandons the transaction.
    in_valid   = 1'b1;
    in_memop   = MEMOP_LD;
    in_alu_out = 64'h4000;
    in_pc      = 64'h13C;
    in_rd_idx  = 5'd7;
    @(negedge clk);
    in_valid       = 1'b0;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_pc", out_pc, 64'd0);
    chk("arst_wb_data", out_wb_data, 64'd0);
    @(negedge clk);
    rst_n          = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("late_rsp_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("late_rsp_out_valid", 64'(out_valid), 64'd0);
    chk("late_rsp_wb_data", out_wb_data, 64'd0);

    // Stage is usable again after the abandoned transaction.
    txn(MEMOP_NONE, 64'hCAFE, 64'h0, 64'h140, 64'h0, 0, 0, 0, 1'b0, 1'b0, 8'h00, 64'h0, 64'hCAFE, 1'b1);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
